psd_frame_accumulator: RTL

Sink for the 32-bit power-spectrum result stream (`m_axis_result_tdata`/`tvalid`) produced by the spectrum pipeline. It consumes the stream in frames of 2^FFT_WIDTH bins and sums a software-selected number of consecutive frames bin-by-bin into an internal accumulation RAM. It then flags completion so software can read the averaged spectrum through a simple read port. It is the consumer end of the result stream: it never stalls the producer.

---
 rtl/psd_frame_accumulator.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/psd_frame_accumulator.sv
// Power-spectrum frame accumulator: sums n_avg consecutive frames of the result
// stream bin-by-bin into a RAM, then exposes the sums through a registered read port.
module psd_frame_accumulator #(
   parameter int unsigned FFT_WIDTH  = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned AVG_WIDTH  = 8
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
   input  logic                            s_axis_tvalid,
   input  logic                            start,
   input  logic [AVG_WIDTH-1:0]            n_avg,
   output logic                            busy,
   output logic                            done,
   output logic [AVG_WIDTH-1:0]            frame_count,
   input  logic [FFT_WIDTH-1:0]            rd_addr,
   output logic [DATA_WIDTH+AVG_WIDTH-1:0] rd_data
);

   localparam int unsigned ACC_WIDTH = DATA_WIDTH + AVG_WIDTH;
   localparam int unsigned NBINS     = 1 << FFT_WIDTH;
   localparam logic [FFT_WIDTH-1:0] LAST_BIN = '1;
   localparam logic [AVG_WIDTH-1:0] AVG_ONE  = {{(AVG_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ACCUM, ST_DONE} state_t;

   state_t                 r_state, w_state_nxt;
   logic [FFT_WIDTH-1:0]   r_bin;
   logic [AVG_WIDTH-1:0]   r_navg, r_in_frames, r_frame_count, w_in_frames_inc;
   logic                   w_busy, w_start_ok, w_accept, w_eof, w_fin;

   logic                   r_p0_vld, r_p0_ovr, r_p0_eof, r_p0_fin;
   logic [FFT_WIDTH-1:0]   r_p0_addr;
   logic [DATA_WIDTH-1:0]  r_p0_data;
   logic                   r_p1_vld, r_p1_ovr, r_p1_eof, r_p1_fin;
   logic [FFT_WIDTH-1:0]   r_p1_addr;
   logic [DATA_WIDTH-1:0]  r_p1_data;
   logic                   r_p2_eof, r_p2_fin;

   logic [ACC_WIDTH-1:0]   r_mem [0:NBINS-1];
   logic [ACC_WIDTH-1:0]   r_ram_q, w_sum, w_data_ext;
   logic [FFT_WIDTH-1:0]   w_rd_addr;

   assign w_busy          = (r_state == ST_ARMED) || (r_state == ST_ACCUM);
   assign w_start_ok      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_in_frames_inc = r_in_frames + 1'b1;
   assign w_eof           = (r_bin == LAST_BIN);
   // r_in_frames counts frames at the input side so late beats of the final frame
   // are cut off immediately, before the pipelined frame_count catches up.
   assign w_accept        = s_axis_tvalid &&
                            (((r_state == ST_ARMED) && (r_bin == '0)) ||
                             ((r_state == ST_ACCUM) && (r_in_frames != r_navg)));
   assign w_fin           = w_eof && (w_in_frames_inc == r_navg);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (start)    w_state_nxt = ST_ARMED;
         ST_ARMED:         if (w_accept) w_state_nxt = ST_ACCUM;
         ST_ACCUM:         if (r_p2_fin) w_state_nxt = ST_DONE;
         default:                        w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_bin         <= '0;
         r_navg        <= AVG_ONE;
         r_in_frames   <= '0;
         r_frame_count <= '0;
         r_p0_vld      <= 1'b0;
         r_p0_ovr      <= 1'b0;
         r_p0_eof      <= 1'b0;
         r_p0_fin      <= 1'b0;
         r_p0_addr     <= '0;
         r_p0_data     <= '0;
         r_p1_vld      <= 1'b0;
         r_p1_ovr      <= 1'b0;
         r_p1_eof      <= 1'b0;
         r_p1_fin      <= 1'b0;
         r_p1_addr     <= '0;
         r_p1_data     <= '0;
         r_p2_eof      <= 1'b0;
         r_p2_fin      <= 1'b0;
      end else begin
         if (s_axis_tvalid) r_bin <= r_bin + 1'b1;

         if (w_start_ok) begin
            r_navg        <= (n_avg == '0) ? AVG_ONE : n_avg;
            r_in_frames   <= '0;
            r_frame_count <= '0;
         end else begin
            if (w_accept && w_eof) r_in_frames   <= w_in_frames_inc;
            if (r_p2_eof)          r_frame_count <= r_frame_count + 1'b1;
         end

         r_p0_vld  <= w_accept;
         r_p0_ovr  <= (r_in_frames == '0);
         r_p0_eof  <= w_accept && w_eof;
         r_p0_fin  <= w_accept && w_fin;
         r_p0_addr <= r_bin;
         r_p0_data <= s_axis_tdata;

         r_p1_vld  <= r_p0_vld;
         r_p1_ovr  <= r_p0_ovr;
         r_p1_eof  <= r_p0_eof;
         r_p1_fin  <= r_p0_fin;
         r_p1_addr <= r_p0_addr;
         r_p1_data <= r_p0_data;

         r_p2_eof  <= r_p1_eof;
         r_p2_fin  <= r_p1_fin;
      end
   end

   assign w_data_ext = {{AVG_WIDTH{1'b0}}, r_p1_data};
   assign w_sum      = r_p1_ovr ? w_data_ext : (r_ram_q + w_data_ext);
   assign w_rd_addr  = w_busy ? r_p0_addr : rd_addr;

   always_ff @(posedge clk) begin
      if (resetn && r_p1_vld) r_mem[r_p1_addr] <= w_sum;
   end

   always_ff @(posedge clk) begin
      if (!resetn) r_ram_q <= '0;
      else         r_ram_q <= r_mem[w_rd_addr];
   end

   assign busy        = w_busy;
   assign done        = (r_state == ST_DONE);
   assign frame_count = r_frame_count;
   assign rd_data     = w_busy ? '0 : r_ram_q;

endmodule
